// File: rtl/inst_fetch_ctrl.sv
// Fetch sequencer between the PC/redirect logic, the I-cache and a dual-write
// instruction FIFO. One I-cache request is kept in flight at a time; each
// request fetches an aligned pair of words at the fetch PC (one word at the
// end of a cache line). Returned words are pushed into the FIFO with their
// PCs. A redirect flushes the FIFO and any in-flight response is discarded.
//
// Ports:
//   clk_i, rst_ni              clock (rising edge), async active-low reset
//   stall_i                    hold off new requests (in-flight ones complete)
//   redirect_valid_i/pc_i      one-cycle restart of fetch at redirect_pc_i
//   fifo_full_i                FIFO cannot take two more entries
//   fifo_rst_o                 registered FIFO flush
//   fifo_we{1,2}_o             slot write enables (slot 2 = word at PC+4)
//   fifo_waddr{1,2}_o          PCs of the written words
//   fifo_wdata{1,2}_o          written instruction words
//   inst_req_o, inst_addr_o    I-cache request and its address
//   inst_addr_ok_i             request accepted
//   inst_data_ok_i             response valid
//   inst_rdata{1,2}_i          words at inst_addr and inst_addr+4
//   fetch_pc_o                 current fetch PC

module inst_fetch_ctrl #(
  parameter logic [31:0] ResetPc   = 32'hBFC0_0000,
  parameter int unsigned LineBytes = 32
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        stall_i,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        fifo_full_i,
  output logic        fifo_rst_o,
  output logic        fifo_we1_o,
  output logic        fifo_we2_o,
  output logic [31:0] fifo_waddr1_o,
  output logic [31:0] fifo_waddr2_o,
  output logic [31:0] fifo_wdata1_o,
  output logic [31:0] fifo_wdata2_o,
  output logic        inst_req_o,
  output logic [31:0] inst_addr_o,
  input  logic        inst_addr_ok_i,
  input  logic        inst_data_ok_i,
  input  logic [31:0] inst_rdata1_i,
  input  logic [31:0] inst_rdata2_i,
  output logic [31:0] fetch_pc_o
);

  localparam int unsigned OffW = $clog2(LineBytes);

  typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic        stale_q, stale_d;
  logic        fifo_rst_q, fifo_rst_d;

  logic        last;
  logic        resp_write;
  logic [31:0] redirect_tgt;
  logic        unused_redirect_lsb;

  assign redirect_tgt        = {redirect_pc_i[31:2], 2'b00};
  assign unused_redirect_lsb = ^redirect_pc_i[1:0];

  // Last word of the cache line: only one word of the pair is meaningful.
  assign last = &fetch_pc_q[OffW-1:2];

  // A redirect in the response cycle wins over the data.
  assign resp_write = (state_q == StWait) & inst_data_ok_i & ~stale_q & ~redirect_valid_i;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_addr_d = req_addr_q;
    stale_d    = stale_q;
    fifo_rst_d = redirect_valid_i;

    unique case (state_q)
      StIdle: begin
        // FIFO space is only sampled here; with one request outstanding the
        // count cannot grow before the response lands.
        if (!fifo_full_i && !stall_i && !redirect_valid_i) begin
          state_d    = StReq;
          req_addr_d = fetch_pc_q;
        end
      end
      StReq: begin
        // The request address is held even across a redirect; the response
        // is then marked stale and dropped.
        if (redirect_valid_i) stale_d = 1'b1;
        if (inst_addr_ok_i)   state_d = StWait;
      end
      StWait: begin
        // Always back through idle so fifo_full is re-sampled after the write.
        if (inst_data_ok_i) begin
          state_d = StIdle;
          stale_d = 1'b0;
        end else if (redirect_valid_i) begin
          stale_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (redirect_valid_i) begin
      fetch_pc_d = redirect_tgt;
    end else if (resp_write) begin
      fetch_pc_d = fetch_pc_q + (last ? 32'd4 : 32'd8);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      fetch_pc_q <= ResetPc;
      req_addr_q <= ResetPc;
      stale_q    <= 1'b0;
      fifo_rst_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_addr_q <= req_addr_d;
      stale_q    <= stale_d;
      fifo_rst_q <= fifo_rst_d;
    end
  end

  assign inst_req_o    = (state_q == StReq);
  assign inst_addr_o   = (state_q == StReq) ? req_addr_q : fetch_pc_q;
  assign fetch_pc_o    = fetch_pc_q;
  assign fifo_rst_o    = fifo_rst_q;
  assign fifo_we1_o    = resp_write;
  assign fifo_we2_o    = resp_write & ~last;
  assign fifo_waddr1_o = fetch_pc_q;
  assign fifo_waddr2_o = fetch_pc_q + 32'd4;
  assign fifo_wdata1_o = inst_rdata1_i;
  assign fifo_wdata2_o = inst_rdata2_i;

endmodule
